// File: rtl/rr_dispatch_ctrl.sv
// rr_dispatch_ctrl: two-entry in-order hold buffer dispatching an RR instruction pair to reservation stations
module rr_dispatch_ctrl #(
  parameter int PW   = 240,
  parameter int NRES = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid1,
  input  logic [1:0]      in_res1,
  input  logic [PW-1:0]   in_pay1,
  input  logic            in_valid2,
  input  logic [1:0]      in_res2,
  input  logic [PW-1:0]   in_pay2,
  output logic            in_ready,
  input  logic [NRES-1:0] rs_full,
  output logic            wr1_en,
  output logic [1:0]      wr1_res,
  output logic [PW-1:0]   wr1_pay,
  output logic            wr2_en,
  output logic [1:0]      wr2_res,
  output logic [PW-1:0]   wr2_pay,
  output logic [CNTW-1:0] stall_cnt
);
  logic va, vb, go_a, go_b, drain, stall;
  logic [1:0] ra, rb;
  logic [PW-1:0] pa, pb;
  assign go_a = va & ~flush & ~rs_full[ra];
  assign go_b = vb & ~flush & ~rs_full[rb] & go_a & (rb != ra);
  assign drain = (~va | go_a) & (~vb | go_b);
  assign in_ready = drain & ~flush;
  assign stall = va & ~drain & ~flush & ~&stall_cnt;
  assign wr1_en = go_a;
  assign wr1_res = ra;
  assign wr1_pay = pa;
  assign wr2_en = go_b;
  assign wr2_res = rb;
  assign wr2_pay = pb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      va <= 1'b0;
      vb <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        va <= 1'b0;
        vb <= 1'b0;
      end else if (in_ready) begin
        va <= in_valid1 | in_valid2;
        vb <= in_valid1 & in_valid2;
      end else if (go_a) begin
        va <= vb;
        vb <= 1'b0;
      end
      if (stall) stall_cnt <= stall_cnt + 1'b1;
    end
  // Entry contents are qualified by va/vb, so they need no reset.
  always_ff @(posedge clk)
    if (in_ready) begin
      ra <= in_valid1 ? in_res1 : in_res2;
      pa <= in_valid1 ? in_pay1 : in_pay2;
      rb <= in_res2;
      pb <= in_pay2;
    end else if (go_a) begin
      ra <= rb;
      pa <= pb;
    end
endmodule

// File: tb/tb_rr_dispatch_ctrl.sv
// tb_rr_dispatch_ctrl: scoreboard bench for rr_dispatch_ctrl
module tb_rr_dispatch_ctrl;
  localparam int PW = 240;
  localparam int NRES = 4;
  localparam int CNTW = 16;
  typedef struct packed {
    logic [1:0] res;
    logic [PW-1:0] pay;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [1:0] in_res1 = '0, in_res2 = '0;
  logic [PW-1:0] in_pay1 = '0, in_pay2 = '0;
  logic [NRES-1:0] rs_full = '0;
  logic in_ready, wr1_en, wr2_en;
  logic [1:0] wr1_res, wr2_res;
  logic [PW-1:0] wr1_pay, wr2_pay;
  logic [CNTW-1:0] stall_cnt;
  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;
  rr_dispatch_ctrl #(.PW(PW), .NRES(NRES), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid1(in_valid1), .in_res1(in_res1), .in_pay1(in_pay1),
    .in_valid2(in_valid2), .in_res2(in_res2), .in_pay2(in_pay2),
    .in_ready(in_ready), .rs_full(rs_full),
    .wr1_en(wr1_en), .wr1_res(wr1_res), .wr1_pay(wr1_pay),
    .wr2_en(wr2_en), .wr2_res(wr2_res), .wr2_pay(wr2_pay),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [PW-1:0] rnd_pay();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 30; i++) p[i*30 +: 30] = 30'($urandom());
    return p;
  endfunction
  // Scoreboard pop point: every write seen this cycle must match the oldest expected entry, then clock.
  task automatic step();
    if (wr1_en) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_wr1 unexpected write res=%0d, queue empty", wr1_res);
      end else begin
        e = q.pop_front();
        if (wr1_res !== e.res || wr1_pay !== e.pay) begin
          fails++;
          $display("FAIL sb_wr1 got res=%0d pay=%h want res=%0d pay=%h", wr1_res, wr1_pay[31:0], e.res, e.pay[31:0]);
        end
      end
    end
    if (wr2_en) begin
      tests++;
      if (!wr1_en) begin
        fails++;
        $display("FAIL sb_order wr2_en=1 while wr1_en=0");
      end
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_wr2 unexpected write res=%0d, queue empty", wr2_res);
      end else begin
        e = q.pop_front();
        if (wr2_res !== e.res || wr2_pay !== e.pay) begin
          fails++;
          $display("FAIL sb_wr2 got res=%0d pay=%h want res=%0d pay=%h", wr2_res, wr2_pay[31:0], e.res, e.pay[31:0]);
        end
      end
      if (wr1_en && wr1_res === wr2_res) begin
        fails++;
        $display("FAIL sb_same_station both ports target %0d", wr1_res);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    rs_full = '0;
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_pair(input logic v1, input logic [1:0] r1, input logic v2, input logic [1:0] r2);
    in_valid1 = v1;
    in_res1 = r1;
    in_pay1 = rnd_pay();
    in_valid2 = v2;
    in_res2 = r2;
    in_pay2 = rnd_pay();
    if (v1) q.push_back({r1, in_pay1});
    if (v2) q.push_back({r2, in_pay2});
  endtask
  task automatic idle();
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask
  task automatic check_ports(input string name, input logic e1, input logic e2, input logic erdy);
    #1;
    tests++;
    if (wr1_en !== e1 || wr2_en !== e2 || in_ready !== erdy) begin
      fails++;
      $display("FAIL %s got wr1_en=%b wr2_en=%b in_ready=%b want %b %b %b", name, wr1_en, wr2_en, in_ready, e1, e2, erdy);
    end
  endtask
  task automatic check_cnt(input string name, input int exp_cnt);
    tests++;
    if (stall_cnt !== CNTW'(exp_cnt)) begin
      fails++;
      $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, exp_cnt);
    end
  endtask
  task automatic check_drained(input string name);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s %0d expected writes never seen, want 0", name, q.size());
    end
  endtask
  task automatic test_reset();
    do_reset();
    check_ports("reset_ports", 1'b0, 1'b0, 1'b1);
    check_cnt("reset_cnt", 0);
  endtask
  task automatic test_pair_diff();
    do_reset();
    drive_pair(1'b1, 2'd0, 1'b1, 2'd2);
    check_ports("t1_accept", 1'b0, 1'b0, 1'b1);
    step();
    idle();
    check_ports("t1_dispatch", 1'b1, 1'b1, 1'b1);
    step();
    check_ports("t1_after", 1'b0, 1'b0, 1'b1);
    check_cnt("t1_cnt", 0);
    check_drained("t1_drain");
  endtask
  task automatic test_same_station();
    do_reset();
    drive_pair(1'b1, 2'd1, 1'b1, 2'd1);
    check_ports("t2_accept", 1'b0, 1'b0, 1'b1);
    step();
    idle();
    check_ports("t2_n1", 1'b1, 1'b0, 1'b0);
    step();
    check_ports("t2_n2", 1'b1, 1'b0, 1'b1);
    step();
    check_cnt("t2_cnt", 1);
    check_drained("t2_drain");
  endtask
  task automatic test_full_stall();
    do_reset();
    rs_full = 4'b1000;
    drive_pair(1'b1, 2'd3, 1'b1, 2'd0);
    check_ports("t3_accept", 1'b0, 1'b0, 1'b1);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      check_ports("t3_blocked", 1'b0, 1'b0, 1'b0);
      step();
    end
    check_cnt("t3_cnt", 3);
    rs_full = '0;
    check_ports("t3_release", 1'b1, 1'b1, 1'b1);
    step();
    check_cnt("t3_cnt_hold", 3);
    check_drained("t3_drain");
  endtask
  task automatic test_flush();
    do_reset();
    rs_full = 4'b1111;
    drive_pair(1'b1, 2'd0, 1'b1, 2'd1);
    step();
    idle();
    check_ports("t4_held", 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b1;
    rs_full = '0;
    check_ports("t4_flush", 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    q.delete();
    check_ports("t4_empty", 1'b0, 1'b0, 1'b1);
    step();
    step();
    check_cnt("t4_cnt", 1);
  endtask
  task automatic test_slot2_only();
    do_reset();
    drive_pair(1'b0, 2'd0, 1'b1, 2'd2);
    step();
    idle();
    check_ports("t5_dispatch", 1'b1, 1'b0, 1'b1);
    tests++;
    if (wr1_res !== 2'd2) begin
      fails++;
      $display("FAIL t5_res got %0d want 2", wr1_res);
    end
    step();
    check_drained("t5_drain");
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_pair(1'b1, 2'(i), 1'b1, 2'(i + 1));
      check_ports("b2b_ready", i > 0, i > 0, 1'b1);
      step();
    end
    idle();
    check_ports("b2b_last", 1'b1, 1'b1, 1'b1);
    step();
    check_cnt("b2b_cnt", 0);
    check_drained("b2b_drain");
  endtask
  task automatic test_async_reset();
    do_reset();
    rs_full = 4'b1111;
    drive_pair(1'b1, 2'd2, 1'b1, 2'd3);
    step();
    idle();
    step();
    check_cnt("t6_pre_cnt", 1);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (wr1_en !== 1'b0 || wr2_en !== 1'b0 || stall_cnt !== '0) begin
      fails++;
      $display("FAIL t6_async got wr1_en=%b wr2_en=%b stall_cnt=%0d want 0 0 0", wr1_en, wr2_en, stall_cnt);
    end
    q.delete();
    rs_full = '0;
    #1;
    rst_n = 1'b1;
    check_ports("t6_after", 1'b0, 1'b0, 1'b1);
    step();
    step();
  endtask
  initial begin
    test_reset();
    test_pair_diff();
    test_same_station();
    test_full_stall();
    test_flush();
    test_slot2_only();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
